// File: rtl/serial_magnitude_cmp_pkg.sv
// Package: serial_cmp_pkg
// Shared types and helpers for the serial magnitude comparator.
//   state_t    : controller states IDLE -> SHIFT -> DONE
//   rel_t      : running relation between the operands (bit1 = less)
//   rel_decode : maps a relation onto the one-hot {lt, eq, gt} result
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ = 2'b00,
    REL_GT = 2'b01,
    REL_LT = 2'b10
  } rel_t;

  // One-hot {lt, eq, gt}; an unused encoding reads as "equal" so the
  // outputs can never show zero or several flags at once.
  function automatic logic [2:0] rel_decode(input rel_t rel);
    case (rel)
      REL_LT:  return 3'b100;
      REL_GT:  return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

endpackage

// File: rtl/serial_magnitude_cmp_shreg.sv
// Module: shift_load_reg_p
// Operand register for the serial comparator: parallel load, or shift left
// by DIGIT bits with zero fill. Load wins when both are requested.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset, clears the register
//   load    : capture d this edge
//   shift   : shift left by DIGIT this edge (ignored while load is high)
//   d       : parallel load data, WIDTH bits
//   q       : register contents, WIDTH bits
module shift_load_reg_p
  import serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next value: a fresh operand takes priority over consuming a digit.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (shift) begin
      q_d = q_q << DIGIT;
    end
  end

  // Register with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/serial_magnitude_cmp.sv
// Module: serial_magnitude_cmp
// Multi-cycle magnitude comparator. Operands are captured in parallel on a
// start request and compared DIGIT bits per cycle, MSB first. Signed mode
// flips the sign bit of both operands so that two's-complement order becomes
// plain unsigned order, letting one unsigned digit compare serve both modes.
// Build option: define SERIAL_CMP_EARLY_EXIT_EN to finish on the first
// differing digit instead of always taking WIDTH/DIGIT cycles.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   start        : compare request, honoured in IDLE or DONE only
//   is_signed    : two's-complement compare when high (sampled with start)
//   a, b         : WIDTH-bit operands (sampled with start)
//   busy         : compare in progress
//   done         : one-cycle pulse, result valid from this cycle
//   lt, eq, gt   : one-hot result, held until the next done
module serial_magnitude_cmp
  import serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int unsigned N = WIDTH / DIGIT;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  generate
    if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("serial_magnitude_cmp: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  state_t           state_q, state_d;
  rel_t             rel_q, rel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       res_q, res_d;

  logic             load;
  logic             shift;
  logic             finish;
  logic [WIDTH-1:0] loadA, loadB;
  logic [WIDTH-1:0] shiftA, shiftB;
  logic [DIGIT-1:0] digitA, digitB;
  logic [WIDTH-1:0] unusedShift;

  assign loadA = a ^ (is_signed ? MSB_MASK : '0);
  assign loadB = b ^ (is_signed ? MSB_MASK : '0);

  shift_load_reg_p #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_shreg_a (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .shift   (shift),
    .d       (loadA),
    .q       (shiftA)
  );

  shift_load_reg_p #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_shreg_b (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .shift   (shift),
    .d       (loadB),
    .q       (shiftB)
  );

  assign digitA = shiftA[WIDTH-1 -: DIGIT];
  assign digitB = shiftB[WIDTH-1 -: DIGIT];

  // Only the top digit of each register feeds the compare; the rest just
  // waits its turn to move up.
  assign unusedShift = shiftA ^ shiftB;

  // Controller: accept in IDLE/DONE, walk the digits in SHIFT. The first
  // unequal digit fixes the relation for good, and the one-hot result is
  // latched only on the edge that enters DONE so it holds in between.
  always_comb begin
    state_d = state_q;
    rel_d   = rel_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    load    = 1'b0;
    shift   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      SHIFT: begin
        shift = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (rel_q == REL_EQ) begin
          if (digitA > digitB) begin
            rel_d = REL_GT;
          end else if (digitA < digitB) begin
            rel_d = REL_LT;
          end
        end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        finish = (cnt_q == CNT_W'(1)) || (rel_d != REL_EQ);
`else
        finish = (cnt_q == CNT_W'(1));
`endif
        if (finish) begin
          state_d = DONE;
          res_d   = rel_decode(rel_d);
        end
      end
      default: begin
        if (start) begin
          state_d = SHIFT;
          load    = 1'b1;
          rel_d   = REL_EQ;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State, relation, digit counter and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rel_q   <= REL_EQ;
      cnt_q   <= '0;
      res_q   <= rel_decode(REL_EQ);
    end else begin
      state_q <= state_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign busy         = (state_q == SHIFT);
  assign done         = (state_q == DONE);
  assign {lt, eq, gt} = res_q;

endmodule

// File: tb/tb_serial_magnitude_cmp.sv
// Bench for serial_magnitude_cmp: four copies (DIGIT = 1, 2, 4, 8, WIDTH 32)
// share one stimulus stream. A latency/result model predicts busy, done and
// the result of every copy each cycle; directed scenarios pin literal values.
module tb_serial_magnitude_cmp;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        isSigned;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  busyV, doneV, ltV, eqV, gtV;

  int vectors = 0;
  int miscompares = 0;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam int LAT_MSB_D1 = 1;
  localparam int LAT_S4_D4  = 7;
`else
  localparam int LAT_MSB_D1 = 32;
  localparam int LAT_S4_D4  = 8;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_magnitude_cmp #(.WIDTH(32), .DIGIT(1 << g)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .is_signed (isSigned),
      .a         (a),
      .b         (b),
      .busy      (busyV[g]),
      .done      (doneV[g]),
      .lt        (ltV[g]),
      .eq        (eqV[g]),
      .gt        (gtV[g])
    );
  end

  // Reference result as one-hot {lt, eq, gt}, straight from integer order.
  function automatic logic [2:0] refResult(input logic [31:0] aIn, input logic [31:0] bIn,
                                           input logic sgn);
    if (sgn) begin
      if ($signed(aIn) < $signed(bIn)) return 3'b100;
      if ($signed(aIn) > $signed(bIn)) return 3'b001;
      return 3'b010;
    end
    if (aIn < bIn) return 3'b100;
    if (aIn > bIn) return 3'b001;
    return 3'b010;
  endfunction

  // Cycles from accept to done: N, or the 1-based index of the first
  // differing digit when early exit is built in.
  function automatic int refLatency(input logic [31:0] aIn, input logic [31:0] bIn,
                                    input logic sgn, input int d);
    logic [31:0] ta = aIn ^ {sgn, 31'b0};
    logic [31:0] tb = bIn ^ {sgn, 31'b0};
    logic [31:0] diff = ta ^ tb;
    int n = 32 / d;
    int firstDiff = n;
    for (int p = 0; p < 32; p++) begin
      if (diff[p]) firstDiff = (31 - p) / d + 1;
    end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    return firstDiff;
`else
    return (firstDiff > 0) ? n : n;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model state per copy: accept edge, latency, pending and visible result.
  int         edgeCnt = 0;
  int         accEdge[4] = '{default: 0};
  int         latCyc[4] = '{default: 0};
  bit         active[4] = '{default: 1'b0};
  logic [2:0] pendRes[4] = '{default: 3'b010};
  logic [2:0] curRes[4] = '{default: 3'b010};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgeCnt = 0;
      for (int i = 0; i < 4; i++) begin
        active[i] = 1'b0;
        curRes[i] = 3'b010;
      end
    end else begin
      edgeCnt++;
      for (int i = 0; i < 4; i++) begin
        if (active[i] && edgeCnt == accEdge[i] + latCyc[i]) curRes[i] = pendRes[i];
        if (start && (!active[i] || edgeCnt - 1 >= accEdge[i] + latCyc[i])) begin
          accEdge[i] = edgeCnt;
          latCyc[i]  = refLatency(a, b, isSigned, 1 << i);
          pendRes[i] = refResult(a, b, isSigned);
          active[i]  = 1'b1;
        end
      end
    end
  end

  // Every falling edge: all copies against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("busy D=%0d", 1 << i), 32'(busyV[i]),
                  32'(active[i] && edgeCnt < accEdge[i] + latCyc[i]));
      checkOutput($sformatf("done D=%0d", 1 << i), 32'(doneV[i]),
                  32'(active[i] && edgeCnt == accEdge[i] + latCyc[i]));
      checkOutput($sformatf("result D=%0d", 1 << i), 32'({ltV[i], eqV[i], gtV[i]}),
                  32'(curRes[i]));
    end
  end

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while ((busyV != 4'b0 || doneV != 4'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) checkOutput("idle wait", 32'(busyV), 32'h0);
  endtask

  // One compare: returns cycles from accept edge to done on copy idx and the
  // result seen in the done cycle (latency -1 on timeout).
  task automatic applyStimulus(input logic [31:0] aIn, input logic [31:0] bIn,
                               input logic sgn, input int idx,
                               output int lat, output logic [2:0] res);
    waitIdle();
    #1;
    start = 1'b1; a = aIn; b = bIn; isSigned = sgn;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (doneV[idx]) begin
        lat = n;
        break;
      end
    end
    res = {ltV[idx], eqV[idx], gtV[idx]};
  endtask

  task automatic genOperands();
    int mode = $urandom_range(0, 3);
    a = $urandom;
    isSigned = 1'($urandom_range(0, 1));
    case (mode)
      0:       b = $urandom;
      1:       b = a;
      2:       b = a ^ (32'h1 << $urandom_range(0, 31));
      default: b = {~a[31], a[30:0]} ^ {31'b0, 1'($urandom_range(0, 1))};
    endcase
  endtask

  initial begin
    int         lat;
    int         doneSeen;
    logic [2:0] res;

    reset_n = 1'b0; start = 1'b0; isSigned = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(busyV), 32'h0);
    checkOutput("reset done", 32'(doneV), 32'h0);
    checkOutput("reset result D=1", 32'({ltV[0], eqV[0], gtV[0]}), 32'h2);
    #1 reset_n = 1'b1;

    applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0, lat, res);
    checkOutput("msb unsigned latency", 32'(lat), 32'(LAT_MSB_D1));
    checkOutput("msb unsigned result", 32'(res), 32'h1);

    applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0, lat, res);
    checkOutput("msb signed latency", 32'(lat), 32'(LAT_MSB_D1));
    checkOutput("msb signed result", 32'(res), 32'h4);

    applyStimulus(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0, lat, res);
    checkOutput("equal unsigned latency", 32'(lat), 32'd32);
    checkOutput("equal unsigned result", 32'(res), 32'h2);

    applyStimulus(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 0, lat, res);
    checkOutput("equal signed latency", 32'(lat), 32'd32);
    checkOutput("equal signed result", 32'(res), 32'h2);

    applyStimulus(32'h0000_0010, 32'h0000_0001, 1'b0, 2, lat, res);
    checkOutput("digit4 latency", 32'(lat), 32'(LAT_S4_D4));
    checkOutput("digit4 result", 32'(res), 32'h1);

    // start re-pulsed mid-compare with new operands is ignored
    waitIdle();
    #1 start = 1'b1; a = 32'h1234_5678; b = 32'h1234_5678; isSigned = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      if (n == 5) begin
        #1 start = 1'b1; a = 32'h1; b = 32'h2;
      end
      if (n == 6) #1 start = 1'b0;
      @(negedge clk);
      if (doneV[0]) begin
        lat = n;
        break;
      end
    end
    checkOutput("ignored start latency", 32'(lat), 32'd32);
    checkOutput("ignored start result", 32'({ltV[0], eqV[0], gtV[0]}), 32'h2);

    // reset mid-compare aborts without a done pulse
    applyStimulus(32'h0000_0003, 32'h0000_0009, 1'b0, 0, lat, res);
    waitIdle();
    #1 start = 1'b1; a = 32'hF000_0000; b = 32'h0F00_0000;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(busyV[0]), 32'h0);
    checkOutput("abort result", 32'({ltV[0], eqV[0], gtV[0]}), 32'h2);
    @(negedge clk);
    #1 reset_n = 1'b1;
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (doneV[0]) doneSeen++;
    end
    checkOutput("abort no done", 32'(doneSeen), 32'h0);

    // start held through DONE: back-to-back compare without a bubble
    waitIdle();
    #1 start = 1'b1; a = 32'd9; b = 32'd2; isSigned = 1'b0;
    @(posedge clk);
    #1 a = 32'd3; b = 32'd5;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (doneV[0]) begin
        lat = n;
        break;
      end
    end
    checkOutput("b2b first result", 32'({ltV[0], eqV[0], gtV[0]}), 32'h1);
    @(negedge clk);
    checkOutput("b2b busy", 32'(busyV[0]), 32'h1);
    checkOutput("b2b done low", 32'(doneV[0]), 32'h0);
    #1 start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (doneV[0]) begin
        lat = n;
        break;
      end
    end
    checkOutput("b2b second seen", 32'(lat > 0), 32'h1);
    checkOutput("b2b second result", 32'({ltV[0], eqV[0], gtV[0]}), 32'h4);

    // random traffic, including requests while busy and occasional resets
    for (int c = 0; c < 30000; c++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 2999) == 0) begin
        reset_n = 1'b0;
        @(negedge clk);
        #1 reset_n = 1'b1;
      end
      start = ($urandom_range(0, 5) == 0);
      genOperands();
    end
    #1 start = 1'b0;
    waitIdle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
